// File: rtl/adder_seq_ctrl.sv
// Serial nibble-wide adder sequencer driving an external 4-bit ripple adder, LS nibble first.
// Latency NIB+1 cycles start->done; start is ignored while busy or done (not queued).
module adder_seq_ctrl #(
   parameter int NIB = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [4*NIB-1:0] op_a,
   input  logic [4*NIB-1:0] op_b,
   input  logic           cin,
   output logic           busy,
   output logic           done,
   output logic [4*NIB-1:0] result,
   output logic           cout,
   output logic [3:0]     add_a,
   output logic [3:0]     add_b,
   output logic           add_ci,
   input  logic [3:0]     add_sum,
   input  logic           add_co
);

   localparam int W  = 4 * NIB;
   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_result;
   logic            r_cout;

   logic            w_last;
   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [W-1:0]    w_result_ins;

   assign w_last = (r_idx == IW'(NIB - 1));

   // Nibble select and result insertion by explicit loop keeps index widths exact.
   always_comb begin
      w_a_nib      = 4'd0;
      w_b_nib      = 4'd0;
      w_result_ins = r_result;
      for (int n = 0; n < NIB; n++) begin
         if (r_idx == IW'(n)) begin
            w_a_nib               = r_a[4*n +: 4];
            w_b_nib               = r_b[4*n +: 4];
            w_result_ins[4*n +: 4] = add_sum;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      add_a       = 4'd0;
      add_b       = 4'd0;
      add_ci      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy   = 1'b1;
            add_a  = w_a_nib;
            add_b  = w_b_nib;
            add_ci = r_carry;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= op_a;
                  r_b      <= op_b;
                  r_carry  <= cin;
                  r_idx    <= '0;
                  r_result <= '0;
                  r_cout   <= 1'b0;
               end
            end
            S_RUN: begin
               r_result <= w_result_ins;
               r_carry  <= add_co;
               if (w_last) r_cout <= add_co;
               else        r_idx  <= r_idx + 1'b1;
            end
            S_DONE: r_idx <= '0;
            default: r_idx <= '0;
         endcase
      end
   end

   assign result = r_result;
   assign cout   = r_cout;

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer that shares one external 4-bit ripple ADDER (sum, c_o, a, b, c_i) to add two NIB-nibble operands serially, least-significant nibble first, one nibble per clock.
- Captures operands on a start request, drives the adder's a/b/c_i every RUN cycle, and collects sum/c_o into a result register.
- Raises a one-cycle done pulse when the add completes. Result and carry feed the board's display decode path, which splits them into tens/units for HEX0/HEX1.

Parameters:
- NIB, 2, number of 4-bit nibbles per operand (legal 1..8). Operand width W = 4*NIB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  add request; sampled only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- cin  input  1  initial carry-in.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and cout are valid from this cycle on.
- result  output  W  accumulated sum.
- cout  output  1  final carry-out.
- add_a  output  4  to ADDER a.
- add_b  output  4  to ADDER b.
- add_ci  output  1  to ADDER c_i.
- add_sum  input  4  from ADDER sum (combinational, same cycle).
- add_co  input  1  from ADDER c_o (combinational, same cycle).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, carry=0.
  - a_reg=0, b_reg=0, result=0, cout=0.
  - busy=0, done=0, add_a=0, add_b=0, add_ci=0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a clock edge: latch a_reg=op_a, b_reg=op_b, carry=cin, idx=0, clear result and cout, go to RUN.
  - On start=0: stay in IDLE; result and cout hold their last values.
- RUN:
  - busy=1.
  - Adder outputs are combinational from registers: add_a=a_reg[4*idx+3:4*idx], add_b=b_reg[4*idx+3:4*idx], add_ci=carry.
  - Each edge: result[4*idx+3:4*idx]=add_sum, carry=add_co.
  - If idx==NIB-1: cout=add_co, go to DONE. Otherwise idx=idx+1.
- DONE: done=1, busy=0. Next edge goes to IDLE and clears idx.
- Adder outputs: add_a, add_b and add_ci are 0 in IDLE and DONE.
- Latency:
  - Start sampled at edge E0.
  - RUN occupies the NIB cycles after E0.
  - done is high in cycle NIB+1 after E0.
  - Total from start to done pulse: NIB+1 cycles.
- Start handling:
  - start in RUN or DONE is ignored, not queued.
  - Operand changes after capture have no effect on the add in progress.
- Held start: start held high continuously gives back-to-back adds with one IDLE cycle between each done pulse and the next RUN.
- Carry: chains only through the carry register; the internal W-bit sum is never formed. The full result is {cout, result}, width W+1.
- Wrap-around: idx counts to exactly NIB-1, never past it. idx width is clog2(NIB), minimum 1.
- Reset mid-RUN: aborts immediately. result, cout and done are cleared, and no done pulse is produced.
- done is never asserted except in the single DONE cycle.

Test Plan (NIB=2):
- Reset, then start with op_a=0x3A, op_b=0x47, cin=0 -> busy high 2 cycles; add_a/add_b show A/7 then 3/4; done pulse on 3rd cycle; result=0x81, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> carry ripples across nibbles; result=0x00, cout=1; add_ci=1 in the second RUN cycle.
- op_a=0xFF, op_b=0xFF, cin=1 -> result=0xFF, cout=1; first RUN cycle add_ci=1.
- Pulse start again in the second RUN cycle with different operands -> ignored; exactly one done pulse; result matches the first operands only.
- Deassert rst_n in the first RUN cycle -> immediate busy=0, result=0, cout=0, state IDLE; no done pulse; a following start computes correctly.
- Hold start=1 across two adds (0x15+0x05, then 0x09+0x01) -> done pulses 4 cycles apart; results 0x1A then 0x0A, cout=0 both.
